// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared trace record, kind and sequencing types for the commit trace unit
package cpu_trace_pkg;
  localparam int TRACE_CNT_W = 32;
  typedef enum logic [2:0] {NOP = 3'd0, REG = 3'd1, LD = 3'd2, ST = 3'd3, HALT = 3'd4} trace_kind_t;
  typedef struct packed {
    trace_kind_t             kind;
    logic [TRACE_CNT_W-1:0]  inum;
    logic [15:0]             pc;
    logic [3:0]              rd;
    logic [15:0]             value;
    logic [15:0]             addr;
  } trace_rec_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} trace_state_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with wrap-bit pointers; push is refused when full even alongside a pop
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;
  always_comb begin
    empty   = wr_q == rd_q;
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop ? rd_q + (AW+1)'(1) : rd_q;
    dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/commit_trace_unit.sv
// commit_trace_unit: classifies retiring instructions into numbered trace records with counters,
// halt/drain sequencing and a runaway-cycle watchdog
module commit_trace_unit
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmt_valid,
  input  logic [15:0]      cmt_pc,
  input  logic             cmt_reg_wr,
  input  logic [3:0]       cmt_rd,
  input  logic [15:0]      cmt_wdata,
  input  logic             cmt_mem_rd,
  input  logic             cmt_mem_wr,
  input  logic [15:0]      cmt_addr,
  input  logic [15:0]      cmt_mdata,
  input  logic             cmt_halt,
  output logic             stall_req,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_kind,
  output logic [CNT_W-1:0] rec_inum,
  output logic [15:0]      rec_pc,
  output logic [3:0]       rec_reg,
  output logic [15:0]      rec_value,
  output logic [15:0]      rec_addr,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic             done,
  output logic             timeout,
  output logic             overflow
);
  trace_state_t     state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d;
  logic             timeout_q, timeout_d, overflow_q, overflow_d, done_q, done_d;
  logic             full, empty, run, accept, wd_hit, has_rd;
  trace_kind_t      kind;
  trace_rec_t       rec_in, rec_out;
  always_comb begin
    kind = cmt_halt ? HALT : (cmt_reg_wr & cmt_mem_rd) ? LD : cmt_reg_wr ? REG : cmt_mem_wr ? ST : NOP;
    has_rd = (kind == REG) || (kind == LD);
    rec_in.kind  = kind;
    rec_in.inum  = TRACE_CNT_W'(inst_q);
    rec_in.pc    = cmt_pc;
    rec_in.rd    = has_rd ? cmt_rd : '0;
    rec_in.value = has_rd ? cmt_wdata : (kind == ST) ? cmt_mdata : '0;
    rec_in.addr  = (kind == LD || kind == ST) ? cmt_addr : '0;
    run    = state_q == RUN;
    accept = cmt_valid & ~full & run;
    wd_hit = run & (cycle_q == CNT_W'(MAX_CYCLES - 1));
    inst_d     = (accept & ~&inst_q) ? inst_q + CNT_W'(1) : inst_q;
    cycle_d    = (run & ~&cycle_q) ? cycle_q + CNT_W'(1) : cycle_q;
    timeout_d  = timeout_q | wd_hit;
    overflow_d = overflow_q | (cmt_valid & full & run);
    state_d    = run ? (((accept & cmt_halt) | wd_hit) ? DRAIN : RUN)
               : (state_q == DRAIN && empty) ? DONE : state_q;
    done_d     = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cycle_q    <= '0;
      inst_q     <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      inst_q     <= inst_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end
  trace_fifo #(.W($bits(trace_rec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (rec_ready),
    .din   (rec_in),
    .dout  (rec_out),
    .full  (full),
    .empty (empty)
  );
  assign stall_req   = full;
  assign rec_valid   = ~empty;
  assign rec_kind    = rec_out.kind;
  assign rec_inum    = CNT_W'(rec_out.inum);
  assign rec_pc      = rec_out.pc;
  assign rec_reg     = rec_out.rd;
  assign rec_value   = rec_out.value;
  assign rec_addr    = rec_out.addr;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit: directed and random commit streams checked against a queue-based trace model
module tb_commit_trace_unit;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int MAXC  = 20;
  logic clk = 0, rst = 1;
  logic cmt_valid = 0, cmt_reg_wr = 0, cmt_mem_rd = 0, cmt_mem_wr = 0, cmt_halt = 0, rec_ready = 0;
  logic [15:0] cmt_pc = 0, cmt_wdata = 0, cmt_addr = 0, cmt_mdata = 0;
  logic [3:0] cmt_rd = 0;
  logic stall_req, rec_valid, done, timeout, overflow;
  logic [2:0] rec_kind;
  logic [CNT_W-1:0] rec_inum, cycle_count, inst_count;
  logic [15:0] rec_pc, rec_value, rec_addr;
  logic [3:0] rec_reg;
  always #5 clk = ~clk;
  commit_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_reg_wr(cmt_reg_wr),
    .cmt_rd(cmt_rd), .cmt_wdata(cmt_wdata), .cmt_mem_rd(cmt_mem_rd), .cmt_mem_wr(cmt_mem_wr),
    .cmt_addr(cmt_addr), .cmt_mdata(cmt_mdata), .cmt_halt(cmt_halt), .stall_req(stall_req),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_inum(rec_inum),
    .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_value(rec_value), .rec_addr(rec_addr),
    .cycle_count(cycle_count), .inst_count(inst_count), .done(done), .timeout(timeout),
    .overflow(overflow)
  );
  typedef struct {int kind; int inum; int pc; int rd; int value; int addr;} exp_rec_t;
  exp_rec_t mq[$];
  int m_inst, m_cyc, m_mode;
  bit m_to, m_ov;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("rec_valid", rec_valid, mq.size() > 0);
    chk("stall_req", stall_req, mq.size() == DEPTH);
    chk("inst_count", inst_count, m_inst);
    chk("cycle_count", cycle_count, m_cyc);
    chk("done", done, m_mode == 2);
    chk("timeout", timeout, m_to);
    chk("overflow", overflow, m_ov);
    if (mq.size() > 0) begin
      chk("rec_kind", rec_kind, mq[0].kind);
      chk("rec_inum", rec_inum, mq[0].inum);
      chk("rec_pc", rec_pc, mq[0].pc);
      chk("rec_reg", rec_reg, mq[0].rd);
      chk("rec_value", rec_value, mq[0].value);
      chk("rec_addr", rec_addr, mq[0].addr);
    end
  endtask
  task automatic step(input bit v, input logic [15:0] pc, input bit rw, input logic [3:0] rd,
                      input logic [15:0] wd, input bit mr, input bit mw, input logic [15:0] ad,
                      input logic [15:0] md, input bit h, input bit rdy);
    exp_rec_t r;
    bit push, pop, was_empty;
    cmt_valid = v; cmt_pc = pc; cmt_reg_wr = rw; cmt_rd = rd; cmt_wdata = wd; cmt_mem_rd = mr;
    cmt_mem_wr = mw; cmt_addr = ad; cmt_mdata = md; cmt_halt = h; rec_ready = rdy;
    push = v && mq.size() < DEPTH && m_mode == 0;
    pop = mq.size() > 0 && rdy;
    was_empty = mq.size() == 0;
    r.kind = h ? 4 : (rw && mr) ? 2 : rw ? 1 : mw ? 3 : 0;
    r.inum = m_inst;
    r.pc = int'(pc);
    r.rd = (r.kind == 1 || r.kind == 2) ? int'(rd) : 0;
    r.value = (r.kind == 1 || r.kind == 2) ? int'(wd) : (r.kind == 3) ? int'(md) : 0;
    r.addr = (r.kind == 2 || r.kind == 3) ? int'(ad) : 0;
    @(posedge clk);
    #1;
    if (m_mode == 0 && v && !push) m_ov = 1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(r);
      m_inst++;
    end
    if (m_mode == 0) begin
      if ((push && h) || m_cyc == MAXC - 1) m_mode = 1;
      if (m_cyc == MAXC - 1) m_to = 1;
      m_cyc++;
    end else if (m_mode == 1 && was_empty) m_mode = 2;
    check_all();
  endtask
  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_valid", rec_valid, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_inst", inst_count, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_kind", rec_kind, 0);
    chk("rst_inum", rec_inum, 0);
    mq.delete();
    m_inst = 0; m_cyc = 0; m_mode = 0; m_to = 0; m_ov = 0;
    cmt_valid = 0; cmt_halt = 0; cmt_reg_wr = 0; cmt_mem_rd = 0; cmt_mem_wr = 0; rec_ready = 0;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    do_reset();
    step(1, 16'h0002, 1, 3, 16'h0005, 0, 0, 0, 0, 0, 1);
    chk("t1_kind", rec_kind, 1);
    chk("t1_inum", rec_inum, 0);
    chk("t1_reg", rec_reg, 3);
    chk("t1_value", rec_value, 16'h0005);
    chk("t1_inst", inst_count, 1);
    do_reset();
    step(1, 16'h0004, 1, 1, 16'hBEEF, 1, 0, 16'h0010, 0, 0, 0);
    step(1, 16'h0006, 0, 0, 0, 0, 1, 16'h0020, 16'h1234, 0, 0);
    chk("t2_ld_kind", rec_kind, 2);
    chk("t2_ld_addr", rec_addr, 16'h0010);
    chk("t2_ld_value", rec_value, 16'hBEEF);
    idle(1);
    chk("t2_st_kind", rec_kind, 3);
    chk("t2_st_addr", rec_addr, 16'h0020);
    chk("t2_st_value", rec_value, 16'h1234);
    chk("t2_st_reg", rec_reg, 0);
    chk("t2_st_inum", rec_inum, 1);
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 16'(2 * i), 1, 4'(i), 16'(i), 0, 0, 0, 0, 0, 0);
    chk("t3_stall", stall_req, 1);
    chk("t3_overflow", overflow, 1);
    chk("t3_inst", inst_count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", rec_inum, i);
      idle(1);
    end
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 16'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 16'h0040, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      if (rec_valid && rec_kind == 3'd4) chk("t4_halt_inum", rec_inum, 3);
      step(1, 16'h0100, 1, 2, 16'h7, 0, 0, 0, 0, 0, i[0]);
    end
    chk("t4_done", done, 1);
    chk("t4_inst", inst_count, 4);
    do_reset();
    for (int i = 0; i < MAXC; i++) idle(1);
    chk("t5_cycle", cycle_count, MAXC);
    chk("t5_timeout", timeout, 1);
    idle(1);
    idle(1);
    chk("t5_done", done, 1);
    chk("t5_frozen", cycle_count, MAXC);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 16'(i), 1, 4'(i), 16'(i), 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 16'h0030, 1, 5, 16'h0009, 0, 0, 0, 0, 0, 0);
    chk("t6_inum", rec_inum, 0);
    for (int e = 0; e < 8; e++) begin
      do_reset();
      for (int i = 0; i < 35; i++)
        step($urandom_range(0, 9) < 7, 16'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 19) == 0,
             1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
